// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter sharing the register-file write port among N_REQ writeback sources.
// Grants are combinational; the winning beat is registered onto the WB_* outputs one cycle later.
module wb_port_arbiter #(
   parameter int N_REQ  = 4,
   parameter int DATA_W = 32
) (
   input  logic                      CLK,
   input  logic                      RESET,
   input  logic [N_REQ-1:0]          REQ_VALID,
   input  logic [5*N_REQ-1:0]        REQ_ADDR,
   input  logic [DATA_W*N_REQ-1:0]   REQ_DATA,
   output logic [N_REQ-1:0]          REQ_READY,
   input  logic                      FREEZE,
   output logic                      WB_WRITE_EN,
   output logic [4:0]                WB_ADDRESS,
   output logic [DATA_W-1:0]         WB_DATA,
   output logic [2:0]                WB_SRC,
   output logic [15:0]               CONFLICT_CNT
);

   localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   logic [N_REQ-1:0][4:0]        lane_addr;
   logic [N_REQ-1:0][DATA_W-1:0] lane_data;

   for (genvar i = 0; i < N_REQ; i++) begin : g_lane
      assign lane_addr[i] = REQ_ADDR[5*i +: 5];
      assign lane_data[i] = REQ_DATA[DATA_W*i +: DATA_W];
   end

   logic [PW-1:0] ptr;
   logic [PW-1:0] gnt_idx;
   logic [PW-1:0] nxt_ptr;
   logic          gnt_any;
   logic          multi_req;
   logic [4:0]    sel_addr;

   // Scan from ptr upward with wrap; the first valid lane wins.
   always_comb begin
      int            j;
      logic [PW-1:0] idx;
      j         = 0;
      idx       = '0;
      gnt_idx   = '0;
      gnt_any   = 1'b0;
      REQ_READY = '0;
      for (int k = 0; k < N_REQ; k++) begin
         j = int'(ptr) + k;
         if (j >= N_REQ) j = j - N_REQ;
         idx = PW'(j);
         if (!gnt_any && REQ_VALID[idx]) begin
            gnt_any = 1'b1;
            gnt_idx = idx;
         end
      end
      if (FREEZE || RESET) gnt_any = 1'b0;
      if (gnt_any) REQ_READY[gnt_idx] = 1'b1;
   end

   assign nxt_ptr   = (gnt_idx == PW'(N_REQ-1)) ? '0 : gnt_idx + PW'(1);
   assign sel_addr  = lane_addr[gnt_idx];
   assign multi_req = |(REQ_VALID & (REQ_VALID - N_REQ'(1)));

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ptr          <= '0;
         WB_WRITE_EN  <= 1'b0;
         WB_ADDRESS   <= '0;
         WB_DATA      <= '0;
         WB_SRC       <= '0;
         CONFLICT_CNT <= '0;
      end else begin
         if (multi_req && CONFLICT_CNT != 16'hFFFF)
            CONFLICT_CNT <= CONFLICT_CNT + 16'd1;
         WB_WRITE_EN <= 1'b0;
         if (gnt_any) begin
            // x0 beats are consumed and still move the pointer, but never assert the write.
            ptr         <= nxt_ptr;
            WB_ADDRESS  <= sel_addr;
            WB_DATA     <= lane_data[gnt_idx];
            WB_SRC      <= 3'(gnt_idx);
            WB_WRITE_EN <= |sel_addr;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Scoreboard bench for wb_port_arbiter: a rotating-queue reference model predicts grants and
// writeback beats; a negedge monitor pops and compares them against the DUT.
module tb_wb_port_arbiter;

   localparam int N  = 4;
   localparam int DW = 32;

   logic              CLK = 1'b0;
   logic              RESET;
   logic [N-1:0]      REQ_VALID;
   logic [5*N-1:0]    REQ_ADDR;
   logic [DW*N-1:0]   REQ_DATA;
   logic [N-1:0]      REQ_READY;
   logic              FREEZE;
   logic              WB_WRITE_EN;
   logic [4:0]        WB_ADDRESS;
   logic [DW-1:0]     WB_DATA;
   logic [2:0]        WB_SRC;
   logic [15:0]       CONFLICT_CNT;

   wb_port_arbiter #(.N_REQ(N), .DATA_W(DW)) dut (
      .CLK(CLK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_ADDR(REQ_ADDR),
      .REQ_DATA(REQ_DATA), .REQ_READY(REQ_READY), .FREEZE(FREEZE),
      .WB_WRITE_EN(WB_WRITE_EN), .WB_ADDRESS(WB_ADDRESS), .WB_DATA(WB_DATA),
      .WB_SRC(WB_SRC), .CONFLICT_CNT(CONFLICT_CNT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic          en;
      logic [4:0]    addr;
      logic [DW-1:0] data;
      logic [2:0]    src;
      logic [15:0]   cnt;
   } wb_t;

   wb_t          wb_q[$];
   logic [N-1:0] rdy_q[$];

   // Reference state: priority order as a queue of indices, plus the committed beat.
   int            order[$];
   logic          m_en;
   logic [4:0]    m_addr;
   logic [DW-1:0] m_data;
   logic [2:0]    m_src;
   logic [15:0]   m_cnt;

   int checks   = 0;
   int failures = 0;

   function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endfunction

   function automatic void model_reset();
      order.delete();
      for (int i = 0; i < N; i++) order.push_back(i);
      m_en = 0; m_addr = 0; m_data = 0; m_src = 0; m_cnt = 0;
   endfunction

   function automatic int model_grant();
      if (FREEZE) return -1;
      foreach (order[k]) if (REQ_VALID[order[k]]) return order[k];
      return -1;
   endfunction

   function automatic void model_commit();
      int g;
      if ($countones(REQ_VALID) > 1 && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
      g = model_grant();
      if (g >= 0) begin
         m_addr = REQ_ADDR[5*g +: 5];
         m_data = REQ_DATA[DW*g +: DW];
         m_src  = 3'(g);
         m_en   = (m_addr != 5'd0);
         while (order[0] != (g + 1) % N) order.push_back(order.pop_front());
      end else begin
         m_en = 1'b0;
      end
   endfunction

   function automatic logic [N-1:0] model_ready();
      int g;
      logic [N-1:0] r;
      r = '0;
      g = model_grant();
      if (g >= 0) r[g] = 1'b1;
      return r;
   endfunction

   task automatic step(input logic [N-1:0] v, input logic [5*N-1:0] a,
                       input logic [DW*N-1:0] d, input logic fz);
      @(posedge CLK);
      if (!RESET) model_commit();
      wb_q.push_back('{m_en, m_addr, m_data, m_src, m_cnt});
      #1;
      REQ_VALID = v; REQ_ADDR = a; REQ_DATA = d; FREEZE = fz;
      rdy_q.push_back(model_ready());
   endtask

   always @(negedge CLK) begin
      wb_t          e;
      logic [N-1:0] r;
      if (!RESET) begin
         if (wb_q.size() > 0) begin
            e = wb_q.pop_front();
            chk("wb_write_en",  WB_WRITE_EN,  e.en);
            chk("wb_address",   WB_ADDRESS,   e.addr);
            chk("wb_data",      WB_DATA,      e.data);
            chk("wb_src",       WB_SRC,       e.src);
            chk("conflict_cnt", CONFLICT_CNT, e.cnt);
         end
         if (rdy_q.size() > 0) begin
            r = rdy_q.pop_front();
            chk("req_ready", REQ_READY, r);
         end
      end
   end

   logic [5*N-1:0]  fa, a;
   logic [DW*N-1:0] fd, d;
   logic            pend[N];
   logic [4:0]      pa[N];
   logic [DW-1:0]   pd[N];
   logic [N-1:0]    v;

   initial begin
      RESET = 1'b1; FREEZE = 1'b0; REQ_VALID = '1; REQ_ADDR = '0; REQ_DATA = '0;
      model_reset();
      for (int i = 0; i < N; i++) begin
         fa[5*i +: 5] = 5'(i + 1);
         fd[DW*i +: DW] = 32'hA000_0000 + 32'(i);
         pend[i] = 1'b0;
      end
      #1;
      chk("rst_write_en", WB_WRITE_EN, 0);
      chk("rst_address", WB_ADDRESS, 0);
      chk("rst_data", WB_DATA, 0);
      chk("rst_src", WB_SRC, 0);
      chk("rst_cnt", CONFLICT_CNT, 0);
      chk("rst_ready", REQ_READY, 0);
      REQ_VALID = '0;
      #11 RESET = 1'b0;

      // Round robin from reset, then idle so the last beat drains.
      for (int i = 0; i < 8; i++) step('1, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);

      // Single request from requester 1, then all valid to show ptr moved to 2.
      a = '0; d = '0;
      a[9:5] = 5'd5; d[63:32] = 32'hDEADBEEF;
      step(4'b0010, a, d, 1'b0);
      step(4'b0000, a, d, 1'b0);
      step('1, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);

      // x0 write from requester 3 (ptr now 3), then freeze with 1001, then release.
      a = fa; d = fd;
      a[19:15] = 5'd0; d[127:96] = 32'h1234;
      step(4'b1000, a, d, 1'b0);
      step(4'b1001, fa, fd, 1'b1);
      step(4'b1001, fa, fd, 1'b1);
      step(4'b1001, fa, fd, 1'b1);
      step(4'b1001, fa, fd, 1'b0);
      step(4'b1000, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);

      // Asynchronous reset 3 ns after a grant edge.
      step('1, fa, fd, 1'b0);
      step('1, fa, fd, 1'b0);
      #2;
      RESET = 1'b1;
      wb_q.delete(); rdy_q.delete(); model_reset();
      #1;
      chk("async_write_en", WB_WRITE_EN, 0);
      chk("async_cnt", CONFLICT_CNT, 0);
      chk("async_ready", REQ_READY, 0);
      chk("async_address", WB_ADDRESS, 0);
      REQ_VALID = 4'b1010;
      @(negedge CLK); #2;
      RESET = 1'b0;
      step('0, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);

      // Randomized traffic obeying the hold-until-ready rule.
      for (int n = 0; n < 2000; n++) begin
         int g;
         g = model_grant();
         if (g >= 0) pend[g] = 1'b0;
         v = '0;
         for (int i = 0; i < N; i++) begin
            if (!pend[i] && $urandom_range(0, 2) == 0) begin
               pend[i] = 1'b1;
               pa[i] = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
               pd[i] = $urandom;
            end
            v[i] = pend[i];
            a[5*i +: 5] = pa[i];
            d[DW*i +: DW] = pd[i];
         end
         step(v, a, d, ($urandom_range(0, 9) == 0));
      end

      // Counter saturation under constant contention.
      for (int n = 0; n < 70000; n++) step('1, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);
      step('0, fa, fd, 1'b0);
      chk("sat_cnt", CONFLICT_CNT, 16'hFFFF);
      @(negedge CLK); #1;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
